// File: rtl/spi_xfer_ctrl.sv
// spi_xfer_ctrl: transfer sequencer and serial-clock generator for one
// spi_shift instance. A host req/ack transfer loads the TX word into the
// shifter, frames it with slave-select setup/hold, pulses go, generates
// s_clk plus the pos_edge/neg_edge strobes while tip is high, and captures
// the received word into rx_data.
//
// Handshake: req is a level; it is sampled only in IDLE. Acceptance happens
// on the clock edge where IDLE sees req=1. tx_data and ss_sel are captured at
// that edge and divider one cycle later (in LOAD); all three are ignored while
// busy. ack is a single-cycle pulse in DONE, with rx_data already valid.
// If req is still high in the IDLE cycle after ack, the next transfer starts.
module spi_xfer_ctrl #(
    parameter int unsigned SS_W   = 8,
    parameter int unsigned DIV_W  = 16,
    parameter int unsigned CS_DLY = 2
) (
    input  logic              clk_shift,
    input  logic              rst_n,
    input  logic              req,
    output logic              ack,
    output logic              busy,
    input  logic [31:0]       tx_data,
    input  logic [SS_W-1:0]   ss_sel,
    input  logic [DIV_W-1:0]  divider,
    output logic [31:0]       rx_data,
    output logic [SS_W-1:0]   ss_n,
    output logic [3:0]        latch,
    output logic [3:0]        byte_sel,
    output logic [31:0]       p_in,
    output logic              go,
    output logic              pos_edge,
    output logic              neg_edge,
    output logic              s_clk,
    input  logic              tip,
    input  logic [31:0]       p_out,
    output logic [2:0]        dbg_state
);

    // Delay counter only has to reach CS_DLY-1; clog2(CS_DLY+1) covers it.
    localparam int unsigned DLY_W = (CS_DLY < 1) ? 1 : $clog2(CS_DLY + 1);
    localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'((CS_DLY < 1) ? 0 : CS_DLY - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LOAD     = 3'd1;
    localparam logic [2:0] ST_CS_SETUP = 3'd2;
    localparam logic [2:0] ST_START    = 3'd3;
    localparam logic [2:0] ST_RUN      = 3'd4;
    localparam logic [2:0] ST_CS_HOLD  = 3'd5;
    localparam logic [2:0] ST_DONE     = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DIV_W-1:0] div_q;
    logic             sclk_q, sclk_d;
    logic [31:0]      tx_q;
    logic [SS_W-1:0]  sel_q;
    logic [31:0]      rx_q;

    logic             in_run;
    logic             clk_active;
    logic             term;
    logic             strobe;
    logic             dly_done;
    logic             accept;
    logic             ss_active;

    assign accept    = (state_q == ST_IDLE) && req;
    assign dly_done  = (dly_q == DLY_LAST);
    assign in_run    = (state_q == ST_RUN);
    // The clock only runs while the shifter reports a transfer in progress;
    // the cycle in which tip is seen low is the exit cycle and stays quiet.
    assign clk_active = in_run && tip;
    assign term      = (cnt_q == div_q);
    assign strobe    = clk_active && term;

    // Next-state and delay-counter logic for the transfer sequence.
    always_comb begin
        state_d = state_q;
        dly_d   = dly_q;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_CS_SETUP;
                dly_d   = '0;
            end
            ST_CS_SETUP: begin
                if (dly_done) begin
                    state_d = ST_START;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_START: begin
                state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!tip) begin
                    state_d = ST_CS_HOLD;
                    dly_d   = '0;
                end
            end
            ST_CS_HOLD: begin
                if (dly_done) begin
                    state_d = ST_DONE;
                    dly_d   = '0;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                dly_d   = '0;
            end
        endcase
    end

    // Half-period counter and serial clock; both are parked at zero outside
    // the active part of RUN, so leaving RUN forces s_clk low without a strobe.
    always_comb begin
        cnt_d  = '0;
        sclk_d = 1'b0;
        if (clk_active) begin
            cnt_d  = term ? '0 : cnt_q + 1'b1;
            sclk_d = sclk_q ^ term;
        end
    end

    // Sequencer state, delay counter and serial-clock registers.
    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            dly_q   <= '0;
            cnt_q   <= '0;
            sclk_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dly_q   <= dly_d;
            cnt_q   <= cnt_d;
            sclk_q  <= sclk_d;
        end
    end

    // Transfer parameters: word and slave mask at acceptance, divider in LOAD.
    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            tx_q  <= '0;
            sel_q <= '0;
            div_q <= '0;
        end else begin
            if (accept) begin
                tx_q  <= tx_data;
                sel_q <= ss_sel;
            end
            if (state_q == ST_LOAD) begin
                div_q <= divider;
            end
        end
    end

    // Received word is captured on the transition from CS_HOLD into DONE.
    always_ff @(posedge clk_shift or negedge rst_n) begin
        if (!rst_n) begin
            rx_q <= '0;
        end else if ((state_q == ST_CS_HOLD) && dly_done) begin
            rx_q <= p_out;
        end
    end

    // Slave select is asserted from CS_SETUP through CS_HOLD inclusive.
    assign ss_active = (state_q == ST_CS_SETUP) || (state_q == ST_START) ||
                       (state_q == ST_RUN)      || (state_q == ST_CS_HOLD);

    assign ss_n      = ss_active ? ~sel_q : {SS_W{1'b1}};
    assign busy      = (state_q != ST_IDLE);
    assign ack       = (state_q == ST_DONE);
    assign go        = (state_q == ST_START);
    assign latch     = (state_q == ST_LOAD) ? 4'b0001 : 4'b0000;
    assign byte_sel  = (state_q == ST_LOAD) ? 4'hF : 4'h0;
    assign p_in      = (state_q == ST_LOAD) ? tx_q : 32'h0;
    assign pos_edge  = strobe && !sclk_q;
    assign neg_edge  = strobe && sclk_q;
    assign s_clk     = sclk_q;
    assign rx_data   = rx_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_xfer_ctrl.sv
// Bench for spi_xfer_ctrl: a behavioural loopback shifter supplies tip and
// p_out; a negedge monitor gathers per-transfer statistics which the directed
// sequence compares against values derived from the transfer parameters.
module tb_spi_xfer_ctrl;
  localparam int SS_W   = 8;
  localparam int DIV_W  = 16;
  localparam int CS_DLY = 2;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              req = 1'b0;
  logic [31:0]       tx_data = '0;
  logic [SS_W-1:0]   ss_sel = '0;
  logic [DIV_W-1:0]  divider = '0;
  logic              ack, busy, go, pos_edge, neg_edge, s_clk, tip;
  logic [31:0]       rx_data, p_in, p_out;
  logic [SS_W-1:0]   ss_n;
  logic [3:0]        latch, byte_sel;
  logic [2:0]        dbg_state;

  spi_xfer_ctrl #(.SS_W(SS_W), .DIV_W(DIV_W), .CS_DLY(CS_DLY)) dut (
    .clk_shift(clk), .rst_n(rst_n), .req(req), .ack(ack), .busy(busy),
    .tx_data(tx_data), .ss_sel(ss_sel), .divider(divider), .rx_data(rx_data),
    .ss_n(ss_n), .latch(latch), .byte_sel(byte_sel), .p_in(p_in), .go(go),
    .pos_edge(pos_edge), .neg_edge(neg_edge), .s_clk(s_clk), .tip(tip),
    .p_out(p_out), .dbg_state(dbg_state)
  );

  int n_checks = 0;
  int n_errors = 0;

  // rotate the low n bits of v left by one, upper bits untouched
  function automatic logic [31:0] rot_low(input logic [31:0] v, input int n);
    logic [31:0] mask;
    mask = (n >= 32) ? 32'hFFFF_FFFF : ((32'h1 << n) - 32'h1);
    return (v & ~mask) | ((((v << 1) | ((v >> (n - 1)) & 32'h1))) & mask);
  endfunction

  // loopback shifter model: tip rises after go, falls after len+1 rising
  // strobes; each falling strobe rotates the word by one bit, so len falling
  // strobes return the original word
  logic        tip_m;
  logic [31:0] sh_m;
  int          pc_m;
  int          len_cfg = 8;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tip_m <= 1'b0;
      sh_m  <= '0;
      pc_m  <= 0;
    end else begin
      if (latch == 4'b0001 && byte_sel == 4'hF) sh_m <= p_in;
      if (go) begin
        tip_m <= 1'b1;
        pc_m  <= 0;
      end else if (tip_m && pos_edge) begin
        pc_m <= pc_m + 1;
        if (pc_m == len_cfg) tip_m <= 1'b0;
      end
      if (tip_m && neg_edge) sh_m <= rot_low(sh_m, len_cfg);
    end
  end
  assign tip   = tip_m;
  assign p_out = sh_m;

  // scoreboard state
  logic [31:0] exp_q[$];
  logic [31:0] rx_got_q[$];
  int          gap_q[$];
  logic [SS_W-1:0] exp_sel = '0;
  int          exp_div = 0;

  int cyc = 0, pos_n, neg_n, go_n, ack_n, latch_n, busy_n;
  int viol, phase_bad, ss_bad, hold_cnt, last_edge_cyc, last_ack_cyc;
  bit first_tog, ack_pend;
  logic prev_pos = 0, prev_neg = 0, prev_sclk = 0, prev_tip = 0;
  logic [SS_W-1:0] ss_h1 = '1, ss_h2 = '1;

  task automatic clear_stats();
    pos_n = 0; neg_n = 0; go_n = 0; ack_n = 0; latch_n = 0; busy_n = 0;
    viol = 0; phase_bad = 0; ss_bad = 0; hold_cnt = 0;
    first_tog = 0; ack_pend = 0; gap_q.delete();
  endtask

  // monitor, sampling on the falling edge
  initial begin
    int exp_int;
    clear_stats();
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        hold_cnt = 0;
        ack_pend = 0;
      end else begin
        if (pos_edge && neg_edge) viol++;
        if ((pos_edge || neg_edge) && !busy) viol++;
        pos_n += int'(pos_edge);
        neg_n += int'(neg_edge);
        busy_n += int'(busy);
        if (prev_pos && !(prev_sclk == 1'b0 && s_clk == 1'b1)) viol++;
        if (prev_neg && !(prev_sclk == 1'b1 && s_clk == 1'b0)) viol++;
        if (s_clk != prev_sclk && !prev_pos && !prev_neg &&
            !(prev_sclk == 1'b1 && s_clk == 1'b0 && prev_tip == 1'b0)) viol++;
        if (s_clk != prev_sclk && (prev_pos || prev_neg)) begin
          exp_int = first_tog ? exp_div + 1 : exp_div + 2;
          if (cyc - last_edge_cyc != exp_int) phase_bad++;
          first_tog = 1;
          last_edge_cyc = cyc;
        end
        if (go) begin
          go_n++;
          last_edge_cyc = cyc;
          first_tog = 0;
          if (ss_n !== ~exp_sel || ss_h1 !== ~exp_sel || ss_h2 !== ~exp_sel) ss_bad++;
        end
        if (hold_cnt > 0) begin
          if (ss_n !== ~exp_sel) ss_bad++;
          hold_cnt--;
        end
        if (prev_tip && !tip_m) hold_cnt = CS_DLY;
        if (ack) begin
          ack_n++;
          if (ss_n !== {SS_W{1'b1}}) ss_bad++;
          rx_got_q.push_back(rx_data);
          last_ack_cyc = cyc;
          ack_pend = 1;
        end
        if (latch == 4'b0001) begin
          latch_n++;
          if (ack_pend) begin
            gap_q.push_back(cyc - last_ack_cyc);
            ack_pend = 0;
          end
        end
      end
      prev_pos = pos_edge; prev_neg = neg_edge;
      prev_sclk = s_clk; prev_tip = tip_m;
      ss_h2 = ss_h1; ss_h1 = ss_n;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_rx(input string tag);
    logic [31:0] e, g;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    g = (rx_got_q.size() > 0) ? rx_got_q.pop_front() : 32'hxxxx_xxxx;
    chk({tag, "/rx"}, g, e);
  endtask

  task automatic wait_acks(input string tag, input int n, input int budget);
    int k = 0;
    while (ack_n < n && k < budget) begin
      @(posedge clk); #1; k++;
    end
    if (ack_n < n) chk({tag, "/timeout"}, ack_n, n);
  endtask

  task automatic xfer_checks(input string tag, input int len);
    chk({tag, "/acks"}, ack_n, 1);
    chk_rx(tag);
    chk({tag, "/pos_n"}, pos_n, len + 1);
    chk({tag, "/neg_n"}, neg_n, len);
    chk({tag, "/go_n"}, go_n, 1);
    chk({tag, "/strobe_viol"}, viol, 0);
    chk({tag, "/phase_bad"}, phase_bad, 0);
    chk({tag, "/ss_bad"}, ss_bad, 0);
  endtask

  // driver: one complete transfer, optionally disturbing inputs mid-RUN
  task automatic do_xfer(input string tag, input logic [31:0] tx, input logic [SS_W-1:0] sel,
                         input int div, input int len, input bit mid_change);
    int k;
    @(posedge clk); #1;
    clear_stats();
    len_cfg = len;
    tx_data = tx; ss_sel = sel; divider = DIV_W'(div);
    exp_sel = sel; exp_div = div;
    exp_q.push_back(tx);
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    if (mid_change) begin
      k = 0;
      while (!tip_m && k < 100) begin @(posedge clk); #1; k++; end
      repeat (3) @(posedge clk);
      #1;
      tx_data = $urandom;
      divider = DIV_W'($urandom_range(5, 20));
      ss_sel = SS_W'($urandom);
    end
    wait_acks(tag, 1, 3000);
    xfer_checks(tag, len);
  endtask

  initial begin
    int k;
    logic [31:0] t;
    // reset state, checked before any clock edge
    #2;
    chk("rst/ss_n", ss_n, {SS_W{1'b1}});
    chk("rst/busy", busy, 0);
    chk("rst/ack", ack, 0);
    chk("rst/s_clk", s_clk, 0);
    chk("rst/go", go, 0);
    chk("rst/rx_data", rx_data, 0);
    chk("rst/p_in", p_in, 0);
    chk("rst/latch", latch, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // basic loopback, fastest clock
    do_xfer("t1", 32'h0000_00A5, 8'h01, 0, 8, 0);
    // slower clock, phase lengths of 4
    do_xfer("t2", $urandom, 8'h80, 3, 8, 0);
    // slave select framing
    do_xfer("t3", $urandom, 8'h04, 1, 8, 0);
    // no slave selected is legal
    do_xfer("t3b", $urandom, 8'h00, 0, 5, 0);

    // back-to-back transfers with req held high
    @(posedge clk); #1;
    clear_stats();
    len_cfg = 8; exp_sel = 8'h02; exp_div = 1;
    tx_data = 32'h1234_5678; ss_sel = 8'h02; divider = 16'd1;
    exp_q.push_back(32'h1234_5678);
    exp_q.push_back(32'hCAFE_0000);
    req = 1'b1;
    k = 0;
    while (latch_n < 1 && k < 100) begin @(posedge clk); #1; k++; end
    tx_data = 32'hCAFE_0000;
    wait_acks("t4", 2, 3000);
    req = 1'b0;
    chk("t4/acks", ack_n, 2);
    chk_rx("t4/first");
    chk_rx("t4/second");
    chk("t4/gap", (gap_q.size() > 0) ? gap_q.pop_front() : -1, 2);
    chk("t4/pos_n", pos_n, 18);
    chk("t4/go_n", go_n, 2);
    chk("t4/phase_bad", phase_bad, 0);
    chk("t4/ss_bad", ss_bad, 0);

    // inputs changed during RUN are ignored
    do_xfer("t5", $urandom, 8'h21, 2, 10, 1);

    // randomized transfers
    for (int i = 0; i < 6; i++) begin
      do_xfer($sformatf("rnd%0d", i), $urandom, SS_W'($urandom),
              $urandom_range(0, 4), $urandom_range(1, 12), 1'($urandom_range(0, 1)));
    end

    // reset in the middle of RUN
    @(posedge clk); #1;
    clear_stats();
    len_cfg = 8; exp_sel = 8'h10; exp_div = 2;
    t = $urandom;
    tx_data = t; ss_sel = 8'h10; divider = 16'd2;
    req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    k = 0;
    while (pos_n < 3 && k < 300) begin @(posedge clk); #1; k++; end
    chk("t6/reached_run", (pos_n >= 3) ? 1 : 0, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6/ss_n", ss_n, {SS_W{1'b1}});
    chk("t6/s_clk", s_clk, 0);
    chk("t6/go", go, 0);
    chk("t6/ack", ack, 0);
    chk("t6/busy", busy, 0);
    chk("t6/rx_data", rx_data, 0);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    clear_stats();
    repeat (20) @(posedge clk);
    #1;
    chk("t6/busy_after", busy_n, 0);
    chk("t6/ack_after", ack_n, 0);
    chk("t6/rx_after", rx_data, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // global watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
endmodule
